// File: rtl/store_align_buffer_pkg.sv
// Shared types for the store alignment buffer: store sizes, queued entry, drain FSM.
package mem_pkg;

  localparam int ENTRY_ADDR_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } st_size_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [31:0]             wdata;
    logic [3:0]              be;
  } store_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/store_align_buffer_if.sv
// CPU store request side and cache write port of the store buffer.
// Optional forwarding-check ports exist only when STORE_FWD_EN is defined.
interface store_align_buffer_if #(parameter int ADDR_W = 32);
  import mem_pkg::*;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  st_size_t          st_size;
  logic              st_err;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byte_enable;
  logic              mem_resp;
  logic              empty;
`ifdef STORE_FWD_EN
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
`endif

  // Buffer side
  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_resp,
`ifdef STORE_FWD_EN
    input  fwd_addr,
    output fwd_hit,
`endif
    output st_ready, st_err, mem_write, mem_address, mem_wdata, mem_byte_enable, empty
  );

  // Pipeline / cache side
  modport master (
    output st_valid, st_addr, st_data, st_size, mem_resp,
`ifdef STORE_FWD_EN
    output fwd_addr,
    input  fwd_hit,
`endif
    input  st_ready, st_err, mem_write, mem_address, mem_wdata, mem_byte_enable, empty
  );

endinterface

// File: rtl/store_align_buffer_aligner.sv
// Combinational store aligner: shifts register data into its byte lanes and
// builds the byte-enable mask; flags stores that cross the word or use size 3.
module store_aligner
  import mem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  st_size_t    size_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misaligned_o
);

  always_comb begin
    wdata_o      = data_i << {off_i, 3'b000};
    be_o         = 4'b0000;
    misaligned_o = 1'b0;
    unique case (size_i)
      SZ_BYTE: be_o = 4'b0001 << off_i;
      SZ_HALF: begin
        be_o         = 4'b0011 << off_i;
        misaligned_o = (off_i == 2'd3);
      end
      SZ_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = (off_i != 2'd0);
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer: aligns CPU stores, queues them in a DEPTH-entry FIFO and drains
// in order to the cache write port. STORE_FWD_EN adds a word-address hit check.
module store_align_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  store_align_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [PW-1:0] ptr_t;

  store_entry_t        mem_q [DEPTH];
  ptr_t                head_q, tail_q, head_nxt;
  logic [CW-1:0]       count_q;
  logic                err_q;
  drain_state_t        state_q, state_d;
  store_entry_t        out_q, load_entry, new_entry;
  logic                load;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_mis;
  logic        st_ready, accept, push, pop;

  store_aligner u_aligner (
    .off_i        (bus.st_addr[1:0]),
    .size_i       (bus.st_size),
    .data_i       (bus.st_data),
    .wdata_o      (al_wdata),
    .be_o         (al_be),
    .misaligned_o (al_mis)
  );

  assign new_entry.addr  = ENTRY_ADDR_W'({bus.st_addr[ADDR_W-1:2], 2'b00});
  assign new_entry.wdata = al_wdata;
  assign new_entry.be    = al_be;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign st_ready = (count_q != CW'(DEPTH));
  assign accept   = bus.st_valid && st_ready;
  assign push     = accept && !al_mis;
  assign pop      = (state_q == WRITE) && bus.mem_resp;
  assign head_nxt = ptr_t'(head_q + 1'b1);

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && al_mis;
      if (push) tail_q <= ptr_t'(tail_q + 1'b1);
      if (pop)  head_q <= head_nxt;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Output registers are loaded with whichever entry becomes head of the write.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_entry = mem_q[head_q];
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = WRITE;
          load    = 1'b1;
        end else if (push) begin
          state_d    = WRITE;
          load       = 1'b1;
          load_entry = new_entry;
        end
      end
      WRITE: begin
        if (bus.mem_resp) begin
          if (count_q != CW'(1)) begin
            load       = 1'b1;
            load_entry = mem_q[head_nxt];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) out_q <= load_entry;
    end
  end

  assign bus.st_ready        = st_ready;
  assign bus.st_err          = err_q;
  assign bus.mem_write       = (state_q == WRITE);
  assign bus.mem_address     = out_q.addr[ADDR_W-1:0];
  assign bus.mem_wdata       = out_q.wdata;
  assign bus.mem_byte_enable = out_q.be;
  assign bus.empty           = (count_q == '0) && (state_q == IDLE);

`ifdef STORE_FWD_EN
  // A slot is live when its distance from head is below the occupancy;
  // the in-flight write stays in the FIFO until mem_resp, so it is covered.
  logic [DEPTH-1:0] hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_fwd
    ptr_t rel;
    assign rel    = ptr_t'(i) - head_q;
    assign hit[i] = (CW'(rel) < count_q) &&
                    (mem_q[i].addr[ADDR_W-1:2] == bus.fwd_addr[ADDR_W-1:2]);
  end
  assign bus.fwd_hit = |hit;
`endif

endmodule
